// File: rtl/if_fetch_queue.sv
// Fetch queue between the IF PC register and the IF/ID boundary: issues in-order
// imem requests under a credit limit, buffers {pc, instr} pairs and drops in-flight fetches on redirect.
module if_fetch_queue #(
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned MAX_OUTST = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [31:0] i_pc_if,
    output logic        o_stall_if,
    input  logic        i_flush,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_valid_id,
    output logic [31:0] o_pc_id,
    output logic [31:0] o_instr_id,
    input  logic        i_ready_id
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned SW = PW + 1;
    localparam int unsigned TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTST + 1);

    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   tag_q       [MAX_OUTST];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [TW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [CW-1:0] live_q, live_d, disc_q, disc_d;
    logic [PW-1:0] fifo_count;
    logic          fifo_empty, fifo_full, credit_ok, grant;
    logic          live_rsp, disc_rsp, fifo_push, fifo_pop;

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUTST - 1)) ? '0 : p + TW'(1);
    endfunction

    always_comb begin
        fifo_count  = wptr_q - rptr_q;
        fifo_empty  = (wptr_q == rptr_q);
        fifo_full   = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        // Discarded responses still hold a memory slot, so they count against MAX_OUTST only.
        credit_ok   = ((SW'(fifo_count) + SW'(live_q)) < SW'(DEPTH))
                   && (((CW+1)'(live_q) + (CW+1)'(disc_q)) < (CW+1)'(MAX_OUTST));
        o_imem_req  = i_reset_n && credit_ok && !i_flush;
        o_imem_addr = i_pc_if;
        grant       = o_imem_req && i_imem_gnt;
        o_stall_if  = !i_reset_n || (!grant && !i_flush);
        disc_rsp    = i_imem_rvalid && (disc_q != '0);
        live_rsp    = i_imem_rvalid && (disc_q == '0);
        fifo_push   = live_rsp && !i_flush;
        fifo_pop    = !fifo_empty && i_ready_id && !i_flush;
        o_valid_id  = !fifo_empty;
        o_pc_id     = fifo_empty ? '0 : pc_mem_q[rptr_q[AW-1:0]];
        o_instr_id  = fifo_empty ? NOP_INSTR : instr_mem_q[rptr_q[AW-1:0]];
    end

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        tag_wr_d = tag_wr_q;
        tag_rd_d = tag_rd_q;
        live_d   = live_q;
        disc_d   = disc_q;
        if (grant)         tag_wr_d = tag_inc(tag_wr_q);
        if (i_imem_rvalid) tag_rd_d = tag_inc(tag_rd_q);
        if (i_flush) begin
            wptr_d = '0;
            rptr_d = '0;
            live_d = '0;
            disc_d = disc_q - CW'(disc_rsp) + live_q - CW'(live_rsp);
        end else begin
            if (fifo_push) wptr_d = wptr_q + PW'(1);
            if (fifo_pop)  rptr_d = rptr_q + PW'(1);
            live_d = live_q + CW'(grant) - CW'(live_rsp);
            disc_d = disc_q - CW'(disc_rsp);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
            live_q   <= '0;
            disc_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
            for (int unsigned i = 0; i < MAX_OUTST; i++) tag_q[i] <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            tag_wr_q <= tag_wr_d;
            tag_rd_q <= tag_rd_d;
            live_q   <= live_d;
            disc_q   <= disc_d;
            if (grant) tag_q[tag_wr_q] <= i_pc_if;
            if (fifo_push) begin
                pc_mem_q[wptr_q[AW-1:0]]    <= tag_q[tag_rd_q];
                instr_mem_q[wptr_q[AW-1:0]] <= i_imem_rdata;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset_n) begin
            assert (!(fifo_push && fifo_full && !fifo_pop))
                else $error("if_fetch_queue: live response written into a full FIFO");
            assert (!(live_rsp && (live_q == '0)))
                else $error("if_fetch_queue: response with no outstanding request");
            assert (((CW+1)'(live_d) + (CW+1)'(disc_d)) <= (CW+1)'(MAX_OUTST))
                else $error("if_fetch_queue: outstanding counter overflow");
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: memory responder model plus an in-order
// scoreboard of {pc, instr} pairs expected at the decode side.
module tb_if_fetch_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b1;
    logic [31:0] i_pc_if = '0;
    logic        o_stall_if;
    logic        i_flush = 1'b0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = '0;
    logic        o_valid_id;
    logic [31:0] o_pc_id;
    logic [31:0] o_instr_id;
    logic        i_ready_id = 1'b0;

    always #5 i_clk = ~i_clk;

    if_fetch_queue #(.DEPTH(2), .MAX_OUTST(2), .NOP_INSTR(NOP)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_pc_if(i_pc_if), .o_stall_if(o_stall_if),
        .i_flush(i_flush), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
        .o_valid_id(o_valid_id), .o_pc_id(o_pc_id), .o_instr_id(o_instr_id),
        .i_ready_id(i_ready_id)
    );

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    int unsigned pops = 0;
    logic [31:0] last_pop_pc = '0;
    logic [31:0] pc_m = '0;
    logic [31:0] flush_tgt = '0;
    logic        gnt_en = 1'b0, rsp_en = 1'b0, rdy_en = 1'b0, flush_en = 1'b0;
    logic [31:0] mem_q[$];
    logic [31:0] exp_q[$];

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], 16'h0033} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h required %h", tag, obs, exp);
    endtask

    // One clock: drive at the falling edge, observe 1 time unit later, advance the models.
    task automatic cycle();
        logic        rv;
        logic        granted;
        logic [31:0] e_pc;
        @(negedge i_clk);
        i_pc_if       = pc_m;
        i_imem_gnt    = gnt_en;
        i_flush       = flush_en;
        i_ready_id    = rdy_en;
        rv            = rsp_en && (mem_q.size() > 0);
        i_imem_rvalid = rv;
        i_imem_rdata  = rv ? instr_of(mem_q[0]) : 32'hDEAD_BEEF;
        #1;
        if (o_valid_id && i_ready_id && !i_flush) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_valid", o_valid_id, 1'b0);
            end else begin
                e_pc = exp_q.pop_front();
                chk("sb_pc", o_pc_id, e_pc);
                chk("sb_instr", o_instr_id, instr_of(e_pc));
                last_pop_pc = o_pc_id;
                pops++;
            end
        end
        granted = o_imem_req && i_imem_gnt;
        if (rv) void'(mem_q.pop_front());
        if (granted) begin
            mem_q.push_back(o_imem_addr);
            exp_q.push_back(pc_m);
        end
        if (i_flush) begin
            exp_q.delete();
            pc_m = flush_tgt;
        end else if (!o_stall_if) begin
            pc_m = pc_m + 32'd4;
        end
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        @(negedge i_clk);
        i_reset_n = 1'b0;
        gnt_en = 1'b0; rsp_en = 1'b0; rdy_en = 1'b0; flush_en = 1'b0;
        i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_flush = 1'b0; i_ready_id = 1'b0;
        mem_q.delete();
        exp_q.delete();
        pc_m = start_pc;
        pops = 0;
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
    endtask

    task automatic run_until_pops(input int unsigned target, input int unsigned budget, input string tag);
        int unsigned n = 0;
        while (pops < target && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, pops, target);
    endtask

    task automatic drain(input string tag);
        int unsigned n = 0;
        gnt_en = 1'b0; rsp_en = 1'b1; rdy_en = 1'b1; flush_en = 1'b0;
        while ((exp_q.size() != 0 || mem_q.size() != 0) && n < 20) begin
            cycle();
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        #2 i_reset_n = 1'b0;
        #1;
        chk("rst_valid", o_valid_id, 1'b0);
        chk("rst_pc", o_pc_id, 32'h0);
        chk("rst_instr", o_instr_id, NOP);
        chk("rst_req", o_imem_req, 1'b0);
        chk("rst_stall", o_stall_if, 1'b1);

        // Streaming
        do_reset(32'h0);
        gnt_en = 1'b1; rsp_en = 1'b1; rdy_en = 1'b1;
        cycle();
        chk("st_req1", o_imem_req, 1'b1);
        chk("st_addr1", o_imem_addr, 32'h0);
        chk("st_valid1", o_valid_id, 1'b0);
        cycle();
        chk("st_valid2", o_valid_id, 1'b0);
        cycle();
        chk("st_valid3", o_valid_id, 1'b1);
        chk("st_pc3", o_pc_id, 32'h0);
        repeat (14) cycle();
        drain("st_drain");
        chk("st_pops_min", pops > 8, 1'b1);

        // Backpressure
        do_reset(32'h0);
        gnt_en = 1'b1; rsp_en = 1'b1; rdy_en = 1'b0;
        cycle();
        cycle();
        cycle();
        chk("bp_req3", o_imem_req, 1'b0);
        cycle();
        chk("bp_req4", o_imem_req, 1'b0);
        chk("bp_stall4", o_stall_if, 1'b1);
        chk("bp_addr4", o_imem_addr, 32'h8);
        chk("bp_valid4", o_valid_id, 1'b1);
        cycle();
        chk("bp_stall5", o_stall_if, 1'b1);
        chk("bp_head5", o_pc_id, 32'h0);
        rdy_en = 1'b1;
        cycle();
        chk("bp_req6", o_imem_req, 1'b0);
        cycle();
        chk("bp_req7", o_imem_req, 1'b1);
        chk("bp_addr7", o_imem_addr, 32'h8);
        chk("bp_pops7", pops, 2);
        drain("bp_drain");
        chk("bp_last", last_pop_pc, 32'h8);

        // Grant stall
        do_reset(32'h10);
        gnt_en = 1'b0; rsp_en = 1'b1; rdy_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("gs_stall", o_stall_if, 1'b1);
            chk("gs_addr", o_imem_addr, 32'h10);
            chk("gs_req", o_imem_req, 1'b1);
        end
        gnt_en = 1'b1;
        cycle();
        chk("gs_stall_grant", o_stall_if, 1'b0);
        gnt_en = 1'b0;
        repeat (4) cycle();
        chk("gs_pops", pops, 1);
        chk("gs_pc", last_pop_pc, 32'h10);

        // Flush with two fetches in flight
        do_reset(32'h20);
        gnt_en = 1'b1; rsp_en = 1'b0; rdy_en = 1'b1;
        cycle();
        cycle();
        gnt_en = 1'b0; flush_en = 1'b1; flush_tgt = 32'h100;
        cycle();
        chk("fl_req", o_imem_req, 1'b0);
        chk("fl_stall", o_stall_if, 1'b0);
        flush_en = 1'b0; rsp_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("fl_valid_low", o_valid_id, 1'b0);
        end
        gnt_en = 1'b1;
        run_until_pops(1, 10, "fl_first_arrives");
        chk("fl_first_pc", last_pop_pc, 32'h100);
        drain("fl_drain");

        // Flush coincident with a live response and a pop
        do_reset(32'h0);
        gnt_en = 1'b1; rsp_en = 1'b0; rdy_en = 1'b0;
        cycle();
        cycle();
        gnt_en = 1'b0; rsp_en = 1'b1;
        cycle();
        rdy_en = 1'b1; flush_en = 1'b1; flush_tgt = 32'h200;
        cycle();
        chk("fc_valid_pre", o_valid_id, 1'b1);
        chk("fc_rvalid", i_imem_rvalid, 1'b1);
        flush_en = 1'b0; rdy_en = 1'b0;
        cycle();
        chk("fc_valid_after", o_valid_id, 1'b0);
        chk("fc_req", o_imem_req, 1'b1);
        chk("fc_addr", o_imem_addr, 32'h200);
        gnt_en = 1'b1; rdy_en = 1'b1;
        cycle();
        gnt_en = 1'b0;
        run_until_pops(1, 6, "fc_new_fetch");
        chk("fc_new_pc", last_pop_pc, 32'h200);

        // Reset with a full FIFO
        do_reset(32'h0);
        gnt_en = 1'b1; rsp_en = 1'b1; rdy_en = 1'b0;
        repeat (5) cycle();
        chk("rm_full_valid", o_valid_id, 1'b1);
        #2 i_reset_n = 1'b0;
        #1;
        chk("rm_valid", o_valid_id, 1'b0);
        chk("rm_instr", o_instr_id, NOP);
        chk("rm_pc", o_pc_id, 32'h0);
        chk("rm_req", o_imem_req, 1'b0);
        chk("rm_stall", o_stall_if, 1'b1);
        do_reset(32'h0);
        gnt_en = 1'b1; rsp_en = 1'b1; rdy_en = 1'b1;
        run_until_pops(1, 6, "rm_restart");
        chk("rm_restart_pc", last_pop_pc, 32'h0);
        drain("rm_drain");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "bench timeout");
    end
endmodule
